ch_readout_sequencer: RTL and testbench
=======================================

# ch_readout_sequencer

Per-channel readout sequencer that sits directly downstream of the channel digital block's SPI serial output. On a frame request it steps `SELECT_REG` through the trigger count and the five timestamp registers (CA..CE), pulses `INST_READOUT` to load each one, and deserialises `CNT_SER`. It then presents each result as a tagged 10-bit word on a valid/ready interface toward the chip-level readout mux.

## Interface
Parameters:
- `WORD_W`, 10: bits per timestamp word; the trigger count is zero-extended to this width.
- `CNT_W`, 3: trigger-count width.
- `SETTLE`, 1: cycles `SELECT_REG` is held stable before `INST_READOUT` (legal range 1..7).

Ports:
- `SPI_CLK` in 1: single clock; all logic is on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: frame request; sampled only in IDLE.
- `BUSY` out 1: high from the cycle after `START` is accepted until the cycle after DONE.
- `SELECT_REG` out 3: register select to the channel; 0 = trigger count, 1..5 = CA..CE.
- `INST_READOUT` out 1: one-cycle load strobe to the channel.
- `CNT_SER` in 1: serial data from the channel, MSB first.
- `WORD_DATA` out `WORD_W`: deserialised word.
- `WORD_TAG` out 3: the `SELECT_REG` value the word came from.
- `WORD_VALID` out 1, `WORD_READY` in 1: output handshake.
- `FRAME_DONE` out 1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, SELECT, LOAD, SHIFT, PRESENT, DONE.
- IDLE → SELECT: on `START`=1. `SELECT_REG` is set to 0.
- SELECT: hold `SELECT_REG` for `SETTLE` cycles, then go to LOAD.
- LOAD: `INST_READOUT`=1 for exactly one cycle, then go to SHIFT.
- SHIFT: sample `CNT_SER` on `WORD_W` consecutive edges, MSB first, into the shift register. The bit counter runs 0..`WORD_W`-1, then the FSM goes to PRESENT.
- PRESENT:
  - `WORD_VALID`=1.
  - `WORD_DATA` and `WORD_TAG` are stable until the handshake completes.
  - Transfer happens on the edge where `WORD_VALID`&`WORD_READY`.
  - After transfer, go to SELECT with `SELECT_REG`+1 if more words remain, else go to DONE.
- Word 0 (the trigger count):
  - Only the low `CNT_W` bits are significant; upper bits are forced to 0 regardless of `CNT_SER`.
  - The low `CNT_W` bits are latched internally as `n_trig`.
- DONE: `FRAME_DONE`=1 for one cycle, then go to IDLE.
- Frame length without the macro: 6 words, tags 0..5.
- `START` while not IDLE is ignored; it is not queued.
- `RST` mid-frame:
  - Return to IDLE next edge.
  - Discard the partial word.
  - Drive all outputs to reset values.
- Reset values:
  - `BUSY`, `INST_READOUT`, `WORD_VALID`, `FRAME_DONE` = 0.
  - `SELECT_REG` = 0, `WORD_DATA` = 0, `WORD_TAG` = 0.
  - `n_trig` = 0, bit counter = 0.

## Timing
- Cycle numbering: `START` is sampled at edge 0.
- Word 0:
  - SELECT covers cycles 1..`SETTLE`.
  - LOAD is cycle `SETTLE`+1.
  - The first data bit is sampled at the end of cycle `SETTLE`+2.
  - `WORD_VALID` rises in cycle `SETTLE`+2+`WORD_W`, which is cycle 13 at the defaults.
- Per-word latency (SELECT entry to VALID) is `SETTLE`+1+`WORD_W` cycles, plus any READY stall.
- With `WORD_READY` tied high, PRESENT lasts exactly one cycle. A 6-word frame then takes 6×13 = 78 cycles from `START` to `FRAME_DONE` at the defaults.
- `SELECT_REG` changes only on entry to SELECT. It is never changed while `INST_READOUT` or SHIFT is active.

## Configuration
- Macro: `PSEC_READOUT_SKIP_EMPTY_EN`.
- Defined:
  - After word 0, only tags 1..min(`n_trig`,5) are read.
  - `n_trig`=0 gives a 1-word frame: `FRAME_DONE` follows the word-0 transfer directly.
  - `n_trig`≥5 gives the full 6-word frame.
- Undefined: always 6 words; `n_trig` is still latched but unused for sequencing.

## Structure
- `types_pkg` holds:
  - `rd_state_t` (enum for the six states).
  - `RD_TAG_TRIGCNT`=0 and `RD_TAG_LAST`=5.
  - The `WORD_W` default constant, shared with the channel readout.
- One sub-module, `ch_readout_deser`: shift register plus bit counter, with enable/clear inputs and a `full` output. The FSM stays in the top module.

## Test plan
- Channel model returns trigger count 3 and CA..CE = 0x3FF, 0x001, 0x155, 0x2AA, 0x000; `WORD_READY`=1; macro off. Required response: words (tag,data) = (0,3), (1,0x3FF), (2,0x001), (3,0x155), (4,0x2AA), (5,0x000), with `FRAME_DONE` at cycle 78.
- Same stimulus with the macro on: exactly 4 words, tags 0..3. Trigger count 0 gives a single word (0,0). Trigger count 7 gives 6 words.
- `WORD_READY` held low for 20 cycles on word 2: `WORD_DATA`=0x001 and tag 2 stay stable, `SELECT_REG` stays 2, and no `INST_READOUT` pulse occurs. Release of READY resumes with word 3.
- `RST` asserted during SHIFT of word 1: all outputs are 0 next cycle. A new `START` then produces a correct full frame beginning at tag 0.
- `START` pulsed again mid-frame: ignored; the frame contains exactly 6 words and there is one `FRAME_DONE`.
- `SETTLE`=3: `INST_READOUT` rises 3 cycles after each `SELECT_REG` change, and the per-word latency is 14 cycles.

Source files
------------

// File: rtl/types_pkg.sv
// Shared readout types: sequencer states, register tags and the timestamp word width
// used by both the channel readout and this sequencer.
package types_pkg;

   localparam int RD_WORD_W = 10;

   localparam logic [2:0] RD_TAG_TRIGCNT = 3'd0;
   localparam logic [2:0] RD_TAG_LAST    = 3'd5;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_SELECT,
      RD_LOAD,
      RD_SHIFT,
      RD_PRESENT,
      RD_DONE
   } rd_state_t;

endpackage

// File: rtl/ch_readout_deser.sv
// MSB-first deserialiser for CNT_SER: shift register plus bit counter; full_o marks the
// cycle in which the last bit of a word is being sampled.
module ch_readout_deser
   import types_pkg::*;
#(
   parameter int WORD_W = RD_WORD_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic              ser_i,
   output logic [WORD_W-1:0] data_o,
   output logic              full_o
);

   localparam int              BC_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);

   logic [WORD_W-1:0] shift_q, shift_d;
   logic [BC_W-1:0]   bit_q, bit_d;

   always_comb begin
      shift_d = shift_q;
      bit_d   = bit_q;
      if (clr_i) begin
         shift_d = '0;
         bit_d   = '0;
      end else if (en_i) begin
         shift_d = {shift_q[WORD_W-2:0], ser_i};
         bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BC_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         bit_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bit_q   <= bit_d;
      end
   end

   assign data_o = shift_q;
   assign full_o = (bit_q == BIT_LAST);

endmodule

// File: rtl/ch_readout_sequencer.sv
// Per-channel readout sequencer: walks SELECT_REG over the trigger count and CA..CE,
// deserialises each register and hands it out on a valid/ready port.
// Optional feature macro PSEC_READOUT_SKIP_EMPTY_EN: skip timestamps beyond the trigger count.
module ch_readout_sequencer
   import types_pkg::*;
#(
   parameter int WORD_W = RD_WORD_W,
   parameter int CNT_W  = 3,
   parameter int SETTLE = 1
) (
   input  logic              SPI_CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic [2:0]        SELECT_REG,
   output logic              INST_READOUT,
   input  logic              CNT_SER,
   output logic [WORD_W-1:0] WORD_DATA,
   output logic [2:0]        WORD_TAG,
   output logic              WORD_VALID,
   input  logic              WORD_READY,
   output logic              FRAME_DONE,
   output rd_state_t         dbg_state_o,
   output logic [CNT_W-1:0]  dbg_ntrig_o
);

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

   rd_state_t         state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [2:0]        settle_q, settle_d;
   logic [CNT_W-1:0]  ntrig_q, ntrig_d;
   logic [WORD_W-1:0] deser_data;
   logic              deser_full;
   logic [2:0]        last_tag;

   ch_readout_deser #(.WORD_W(WORD_W)) u_deser (
      .clk_i  (SPI_CLK),
      .rst_i  (RST),
      .en_i   (state_q == RD_SHIFT),
      .clr_i  (state_q == RD_LOAD),
      .ser_i  (CNT_SER),
      .data_o (deser_data),
      .full_o (deser_full)
   );

`ifdef PSEC_READOUT_SKIP_EMPTY_EN
   // On word 0 the count is still in the shifter; it is latched on the same transfer edge.
   logic [CNT_W-1:0] trig_src;
   assign trig_src = (sel_q == RD_TAG_TRIGCNT) ? deser_data[CNT_W-1:0] : ntrig_q;
   assign last_tag = (32'(trig_src) >= 32'(RD_TAG_LAST)) ? RD_TAG_LAST : 3'(trig_src);
`else
   assign last_tag = RD_TAG_LAST;
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      settle_d = settle_q;
      ntrig_d  = ntrig_q;
      case (state_q)
         RD_IDLE: begin
            if (START) begin
               state_d  = RD_SELECT;
               sel_d    = RD_TAG_TRIGCNT;
               settle_d = '0;
            end
         end
         RD_SELECT: begin
            if (settle_q == SETTLE_LAST) state_d = RD_LOAD;
            else                         settle_d = settle_q + 3'd1;
         end
         RD_LOAD:  state_d = RD_SHIFT;
         RD_SHIFT: if (deser_full) state_d = RD_PRESENT;
         RD_PRESENT: begin
            if (WORD_READY) begin
               if (sel_q == RD_TAG_TRIGCNT) ntrig_d = deser_data[CNT_W-1:0];
               if (sel_q < last_tag) begin
                  state_d  = RD_SELECT;
                  sel_d    = sel_q + 3'd1;
                  settle_d = '0;
               end else begin
                  state_d = RD_DONE;
               end
            end
         end
         RD_DONE: state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge SPI_CLK) begin
      if (RST) begin
         state_q  <= RD_IDLE;
         sel_q    <= '0;
         settle_q <= '0;
         ntrig_q  <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         settle_q <= settle_d;
         ntrig_q  <= ntrig_d;
      end
   end

   // Word 0 carries only the trigger count; its upper bits are never trusted.
   assign WORD_DATA    = (sel_q == RD_TAG_TRIGCNT)
                         ? {{(WORD_W-CNT_W){1'b0}}, deser_data[CNT_W-1:0]} : deser_data;
   assign WORD_TAG     = sel_q;
   assign SELECT_REG   = sel_q;
   assign BUSY         = (state_q != RD_IDLE);
   assign INST_READOUT = (state_q == RD_LOAD);
   assign WORD_VALID   = (state_q == RD_PRESENT);
   assign FRAME_DONE   = (state_q == RD_DONE);
   assign dbg_state_o  = state_q;
   assign dbg_ntrig_o  = ntrig_q;

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Bench for ch_readout_sequencer: channel SPI model, frame driver/monitor and a word-level
// reference model; a second instance runs with SETTLE=3.
module tb_ch_readout_sequencer;
   import types_pkg::*;

   localparam int WORD_W   = 10;
   localparam int CNT_W    = 3;
   localparam int SETTLE_A = 1;
   localparam int SETTLE_B = 3;

   logic SPI_CLK = 1'b0;
   logic RST;
   always #5 SPI_CLK = ~SPI_CLK;

   logic              start_a, busy_a, inst_a, ser_a, valid_a, ready_a, done_a;
   logic [2:0]        sel_a, tag_a;
   logic [WORD_W-1:0] data_a;
   rd_state_t         state_a;
   logic [CNT_W-1:0]  ntrig_a;
   logic              start_b, busy_b, inst_b, ser_b, valid_b, ready_b, done_b;
   logic [2:0]        sel_b, tag_b;
   logic [WORD_W-1:0] data_b;
   rd_state_t         state_b;
   logic [CNT_W-1:0]  ntrig_b;

   ch_readout_sequencer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .SETTLE(SETTLE_A)) u_a (
      .SPI_CLK(SPI_CLK), .RST(RST), .START(start_a), .BUSY(busy_a), .SELECT_REG(sel_a),
      .INST_READOUT(inst_a), .CNT_SER(ser_a), .WORD_DATA(data_a), .WORD_TAG(tag_a),
      .WORD_VALID(valid_a), .WORD_READY(ready_a), .FRAME_DONE(done_a),
      .dbg_state_o(state_a), .dbg_ntrig_o(ntrig_a));

   ch_readout_sequencer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .SETTLE(SETTLE_B)) u_b (
      .SPI_CLK(SPI_CLK), .RST(RST), .START(start_b), .BUSY(busy_b), .SELECT_REG(sel_b),
      .INST_READOUT(inst_b), .CNT_SER(ser_b), .WORD_DATA(data_b), .WORD_TAG(tag_b),
      .WORD_VALID(valid_b), .WORD_READY(ready_b), .FRAME_DONE(done_b),
      .dbg_state_o(state_b), .dbg_ntrig_o(ntrig_b));

   // Channel model: INST_READOUT loads the selected register, then it shifts out MSB first.
   logic [WORD_W-1:0] chan_val [0:7];
   logic [WORD_W-1:0] ch_sh_a, ch_sh_b;
   always @(posedge SPI_CLK) begin
      if (inst_a) ch_sh_a <= chan_val[sel_a];
      else        ch_sh_a <= {ch_sh_a[WORD_W-2:0], 1'b0};
      if (inst_b) ch_sh_b <= chan_val[sel_b];
      else        ch_sh_b <= {ch_sh_b[WORD_W-2:0], 1'b0};
   end
   assign ser_a = ch_sh_a[WORD_W-1];
   assign ser_b = ch_sh_b[WORD_W-1];

   int n_cmp  = 0;
   int n_fail = 0;

   logic [2:0]        exp_tag_q[$];
   logic [WORD_W-1:0] exp_q[$];
   logic [2:0]        obs_tag_q[$];
   logic [WORD_W-1:0] obs_q[$];
   int obs_valid_edge[$], obs_inst_edge[$], obs_sel_edge[$];
   int done_edge, done_cnt, stall_bad, stall_cycles, inst_cycles, busy_bad;
   bit timed_out;
   logic busy_after;

   // Expected frame: (0, count) then one word per non-empty timestamp register.
   task automatic build_expected();
      int n;
      int last;
      exp_tag_q.delete();
      exp_q.delete();
      n = int'(chan_val[0][CNT_W-1:0]);
      exp_tag_q.push_back(3'd0);
      exp_q.push_back(WORD_W'(n));
      last = 5;
`ifdef PSEC_READOUT_SKIP_EMPTY_EN
      last = (n < 5) ? n : 5;
`endif
      for (int t = 1; t <= last; t++) begin
         exp_tag_q.push_back(3'(t));
         exp_q.push_back(chan_val[t]);
      end
   endtask

   task automatic set_directed(input logic [WORD_W-1:0] trig);
      chan_val[0] = trig;
      chan_val[1] = 10'h3FF;
      chan_val[2] = 10'h001;
      chan_val[3] = 10'h155;
      chan_val[4] = 10'h2AA;
      chan_val[5] = 10'h000;
      chan_val[6] = 10'h000;
      chan_val[7] = 10'h000;
   endtask

   // Starts a frame (call at a negedge) and records what the DUT emits; edge c = c-th posedge after START.
   task automatic run_frame(input bit use_b, input int stall_tag, input int stall_len,
                            input bit rand_ready, input int restart_at);
      int c, sc;
      bit pending, ins_prev;
      logic v, r, ins, dn, bsy;
      logic [2:0] s, t, s_prev, snap_t, snap_s;
      logic [WORD_W-1:0] d, snap_d;
      obs_tag_q.delete(); obs_q.delete();
      obs_valid_edge.delete(); obs_inst_edge.delete(); obs_sel_edge.delete();
      done_edge = -1; done_cnt = 0; stall_bad = 0; stall_cycles = 0;
      inst_cycles = 0; busy_bad = 0; timed_out = 0;
      pending = 0; ins_prev = 0; sc = 0; s_prev = '0; snap_t = '0; snap_s = '0; snap_d = '0;
      bsy = 1'b0;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      ready_a = 1'b1; ready_b = 1'b1;
      @(posedge SPI_CLK);
      c = 0;
      @(negedge SPI_CLK);
      start_a = 1'b0; start_b = 1'b0;
      forever begin
         v   = use_b ? valid_b : valid_a;
         ins = use_b ? inst_b  : inst_a;
         dn  = use_b ? done_b  : done_a;
         bsy = use_b ? busy_b  : busy_a;
         s   = use_b ? sel_b   : sel_a;
         t   = use_b ? tag_b   : tag_a;
         d   = use_b ? data_b  : data_a;
         if (c > 0 && s != s_prev) obs_sel_edge.push_back(c);
         s_prev = s;
         if (ins) begin
            inst_cycles++;
            if (!ins_prev) obs_inst_edge.push_back(c);
         end
         ins_prev = ins;
         if (done_edge < 0 && !bsy) busy_bad++;
         if (dn) begin
            done_cnt++;
            if (done_edge < 0) done_edge = c;
         end
         if (pending) begin
            if (!v || d !== snap_d || t !== snap_t || s !== snap_s || ins) stall_bad++;
         end else if (v) begin
            obs_valid_edge.push_back(c);
            snap_d = d; snap_t = t; snap_s = s; sc = 0;
         end
         r = 1'b1;
         if (v) begin
            if (rand_ready) r = ($urandom_range(0, 2) != 0);
            else if (int'(t) == stall_tag && sc < stall_len) begin
               r = 1'b0; sc++; stall_cycles++;
            end
         end
         if (use_b) ready_b = r; else ready_a = r;
         if (v && r) begin
            obs_tag_q.push_back(t);
            obs_q.push_back(d);
         end
         pending = v && !r;
         if (use_b) start_b = (c == restart_at); else start_a = (c == restart_at);
         if (done_edge >= 0 && c >= done_edge + 4) break;
         if (c >= 3000) begin timed_out = 1; break; end
         @(posedge SPI_CLK);
         c++;
         @(negedge SPI_CLK);
      end
      busy_after = bsy;
      ready_a = 1'b1; ready_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
      set_directed(10'd0);
      repeat (3) @(posedge SPI_CLK);
      @(negedge SPI_CLK);
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      n_cmp++; if (inst_a !== 1'b0) begin n_fail++; $display("FAIL reset_inst: got %b want 0", inst_a); end
      n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
      n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
      n_cmp++; if (sel_a !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
      n_cmp++; if (data_a !== '0) begin n_fail++; $display("FAIL reset_data: got 0x%03h want 0", data_a); end
      n_cmp++; if (tag_a !== 3'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", tag_a); end
      n_cmp++; if (ntrig_a !== '0) begin n_fail++; $display("FAIL reset_ntrig: got %0d want 0", ntrig_a); end
      n_cmp++; if (state_a !== RD_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_a); end
      RST = 1'b0;
      repeat (2) @(negedge SPI_CLK);
      n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         n_fail++; $display("FAIL idle_no_start: busy %b/%b want 0/0", busy_a, busy_b);
      end
   endtask

   task automatic test_directed_frame();
      int p;
      set_directed(10'd3);
      build_expected();
      run_frame(0, -1, 0, 0, -1);
      p = SETTLE_A + 2 + WORD_W;
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL directed_timeout: got timeout want FRAME_DONE"); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL directed_count: got %0d words want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_tag_q[i] !== exp_tag_q[i] || obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL directed_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                               i, obs_tag_q[i], obs_q[i], exp_tag_q[i], exp_q[i]);
         end
      end
      for (int k = 0; k < obs_inst_edge.size(); k++) begin
         n_cmp++;
         if (obs_inst_edge[k] != SETTLE_A + k * p) begin
            n_fail++; $display("FAIL directed_inst_edge%0d: got %0d want %0d", k, obs_inst_edge[k], SETTLE_A + k * p);
         end
      end
      for (int k = 0; k < obs_valid_edge.size(); k++) begin
         n_cmp++;
         if (obs_valid_edge[k] != SETTLE_A + 1 + WORD_W + k * p) begin
            n_fail++; $display("FAIL directed_valid_edge%0d: got %0d want %0d", k, obs_valid_edge[k],
                               SETTLE_A + 1 + WORD_W + k * p);
         end
      end
      n_cmp++; if (inst_cycles != exp_q.size()) begin
         n_fail++; $display("FAIL directed_inst_cycles: got %0d want %0d", inst_cycles, exp_q.size());
      end
      n_cmp++; if (done_edge != exp_q.size() * p) begin
         n_fail++; $display("FAIL directed_done_edge: got %0d want %0d", done_edge, exp_q.size() * p);
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL directed_done_count: got %0d want 1", done_cnt); end
      n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL directed_busy_gap: got %0d low cycles want 0", busy_bad); end
      n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL directed_busy_after: got %b want 0", busy_after); end
      n_cmp++; if (ntrig_a !== 3'd3) begin n_fail++; $display("FAIL directed_ntrig: got %0d want 3", ntrig_a); end
   endtask

   task automatic test_trig_counts();
      logic [2:0] trig;
      for (int i = 0; i < 2; i++) begin
         trig = (i == 0) ? 3'd0 : 3'd7;
         for (int j = 1; j < 8; j++) chan_val[j] = WORD_W'($urandom_range(0, 1023));
         chan_val[0] = {7'($urandom_range(1, 127)), trig};
         build_expected();
         run_frame(0, -1, 0, 0, -1);
         n_cmp++; if (timed_out || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL trig%0d_count: got %0d words (timeout %0d) want %0d", trig, obs_q.size(),
                               timed_out, exp_q.size());
         end
         for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_tag_q[k] !== exp_tag_q[k] || obs_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL trig%0d_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                                  trig, k, obs_tag_q[k], obs_q[k], exp_tag_q[k], exp_q[k]);
            end
         end
         n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL trig%0d_done_count: got %0d want 1", trig, done_cnt); end
      end
   endtask

   task automatic test_ready_stall();
      set_directed(10'd3);
      build_expected();
      run_frame(0, 2, 20, 0, -1);
      n_cmp++; if (stall_cycles != 20) begin n_fail++; $display("FAIL stall_cycles: got %0d want 20", stall_cycles); end
      n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_stability: got %0d unstable cycles want 0", stall_bad); end
      n_cmp++; if (timed_out || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d words want %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_cmp++;
         if (obs_tag_q[k] !== exp_tag_q[k] || obs_q[k] !== exp_q[k]) begin
            n_fail++; $display("FAIL stall_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                               k, obs_tag_q[k], obs_q[k], exp_tag_q[k], exp_q[k]);
         end
      end
      n_cmp++; if (done_edge != exp_q.size() * (SETTLE_A + 2 + WORD_W) + 20) begin
         n_fail++; $display("FAIL stall_done_edge: got %0d want %0d", done_edge,
                            exp_q.size() * (SETTLE_A + 2 + WORD_W) + 20);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      set_directed(10'd3);
      start_a = 1'b1;
      @(posedge SPI_CLK);
      @(negedge SPI_CLK);
      start_a = 1'b0;
      guard = 0;
      while (!(inst_a === 1'b1 && sel_a === 3'd1) && guard < 100) begin
         @(negedge SPI_CLK);
         guard++;
      end
      n_cmp++; if (guard >= 100) begin n_fail++; $display("FAIL rstmid_reach_word1: got timeout want load of tag 1"); end
      repeat (3) @(negedge SPI_CLK);
      RST = 1'b1;
      @(negedge SPI_CLK);
      n_cmp++; if ({busy_a, inst_a, valid_a, done_a} !== 4'b0000) begin
         n_fail++; $display("FAIL rstmid_flags: got busy/inst/valid/done=%b want 0000", {busy_a, inst_a, valid_a, done_a});
      end
      n_cmp++; if (sel_a !== 3'd0 || tag_a !== 3'd0 || data_a !== '0) begin
         n_fail++; $display("FAIL rstmid_values: got sel %0d tag %0d data 0x%03h want 0/0/0", sel_a, tag_a, data_a);
      end
      RST = 1'b0;
      build_expected();
      run_frame(0, -1, 0, 0, -1);
      n_cmp++; if (timed_out || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rstmid_count: got %0d words want %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_cmp++;
         if (obs_tag_q[k] !== exp_tag_q[k] || obs_q[k] !== exp_q[k]) begin
            n_fail++; $display("FAIL rstmid_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                               k, obs_tag_q[k], obs_q[k], exp_tag_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_start_ignored();
      set_directed(10'd6);
      build_expected();
      run_frame(0, -1, 0, 0, 40);
      n_cmp++; if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL restart_count: got %0d words want %0d", obs_q.size(), exp_q.size());
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
      n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL restart_queued: got busy %b want 0", busy_after); end
      n_cmp++; if (done_edge != exp_q.size() * (SETTLE_A + 2 + WORD_W)) begin
         n_fail++; $display("FAIL restart_done_edge: got %0d want %0d", done_edge, exp_q.size() * (SETTLE_A + 2 + WORD_W));
      end
   endtask

   task automatic test_settle3();
      int p;
      set_directed(10'd5);
      build_expected();
      run_frame(1, -1, 0, 0, -1);
      p = SETTLE_B + 2 + WORD_W;
      n_cmp++; if (obs_valid_edge.size() == 0 || obs_valid_edge[0] != SETTLE_B + 1 + WORD_W) begin
         n_fail++; $display("FAIL settle3_latency: got %0d want %0d",
                            (obs_valid_edge.size() == 0) ? -1 : obs_valid_edge[0], SETTLE_B + 1 + WORD_W);
      end
      for (int k = 1; k < obs_inst_edge.size() && k <= obs_sel_edge.size(); k++) begin
         n_cmp++;
         if (obs_inst_edge[k] - obs_sel_edge[k-1] != SETTLE_B) begin
            n_fail++; $display("FAIL settle3_sel_to_inst%0d: got %0d want %0d", k,
                               obs_inst_edge[k] - obs_sel_edge[k-1], SETTLE_B);
         end
      end
      n_cmp++; if (obs_inst_edge.size() != exp_q.size()) begin
         n_fail++; $display("FAIL settle3_inst_count: got %0d want %0d", obs_inst_edge.size(), exp_q.size());
      end
      n_cmp++; if (done_edge != exp_q.size() * p) begin
         n_fail++; $display("FAIL settle3_done_edge: got %0d want %0d", done_edge, exp_q.size() * p);
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_cmp++;
         if (obs_tag_q[k] !== exp_tag_q[k] || obs_q[k] !== exp_q[k]) begin
            n_fail++; $display("FAIL settle3_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                               k, obs_tag_q[k], obs_q[k], exp_tag_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) begin
         for (int j = 0; j < 8; j++) chan_val[j] = WORD_W'($urandom_range(0, 1023));
         build_expected();
         run_frame(0, -1, 0, 1, -1);
         n_cmp++; if (timed_out || obs_q.size() != exp_q.size() || done_cnt != 1) begin
            n_fail++; $display("FAIL random%0d_frame: got %0d words, %0d done, timeout %0d want %0d words, 1 done",
                               f, obs_q.size(), done_cnt, timed_out, exp_q.size());
         end
         for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_tag_q[k] !== exp_tag_q[k] || obs_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL random%0d_word%0d: got (%0d,0x%03h) want (%0d,0x%03h)",
                                  f, k, obs_tag_q[k], obs_q[k], exp_tag_q[k], exp_q[k]);
            end
         end
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed_frame();
      test_trig_counts();
      test_ready_stall();
      test_reset_mid();
      test_start_ignored();
      test_settle3();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
